// File: rtl/hex_digit_sequencer_if.sv
// Digit producer handshake: a hex digit plus its decimal-point flag, offered with valid/ready.
interface hex_digit_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_dp;

    modport master (output in_valid, output in_data, output in_dp, input in_ready);
    modport slave  (input in_valid, input in_data, input in_dp, output in_ready);
endinterface

// File: rtl/hex_digit_sequencer.sv
// Queues hex digits and plays them out as active-low seven-segment words,
// each held for a fixed dwell followed by a blank gap.
module hex_digit_sequencer #(
    parameter int DWELL_CYCLES = 32768,
    parameter int GAP_CYCLES   = 4096,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    hex_digit_sequencer_if.slave          in_if,
    output logic [7:0]                    sevenseg_out_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int MAX_CYC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
    localparam logic [7:0]       BLANK      = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       seg_q, seg_d;

    logic [4:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic             full, empty, push, pop;
    logic [4:0]       head;
    logic [7:0]       head_word;

    function automatic logic [6:0] encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // in_ready deliberately ignores a same-cycle pop so it never depends on FSM decode.
    assign full            = (level_q == LVL_FULL);
    assign empty           = (level_q == '0);
    assign in_if.in_ready  = !full && !flush_i;
    assign push            = in_if.in_valid && in_if.in_ready;
    assign head            = mem_q[rd_ptr_q];
    assign head_word       = ~{head[4], encode(head[3:0])};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_if.in_dp, in_if.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Leaving a phase with cnt at zero keeps dwell and gap exact, including length 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        pop     = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            seg_d   = BLANK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    seg_d = BLANK;
                    if (!empty) begin
                        pop     = 1'b1;
                        seg_d   = head_word;
                        cnt_d   = DWELL_LOAD;
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        seg_d   = BLANK;
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else if (!empty) begin
                        pop   = 1'b1;
                        seg_d = head_word;
                        cnt_d = DWELL_LOAD;
                    end else begin
                        seg_d   = BLANK;
                        state_d = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    seg_d = BLANK;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        seg_d   = head_word;
                        cnt_d   = DWELL_LOAD;
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    seg_d   = BLANK;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seg_q   <= BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
        end
    end

    assign sevenseg_out_o = seg_q;
    assign busy_o         = !empty || (state_q != ST_IDLE);
    assign fifo_level_o   = level_q;

endmodule

// File: tb/tb_hex_digit_sequencer.sv
// Bench for hex_digit_sequencer: two instances (gap 2 and gap 0) checked against a
// display-schedule model where each digit starts at max(accept+1, previous start+dwell+gap).
module tb_hex_digit_sequencer;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic flushA = 1'b0;
    logic flushB = 1'b0;

    always #5 clk = ~clk;

    hex_digit_sequencer_if busA ();
    hex_digit_sequencer_if busB ();

    logic [7:0] segA, segB;
    logic       busyA, busyB;
    logic [2:0] lvlA, lvlB;

    hex_digit_sequencer #(.DWELL_CYCLES(4), .GAP_CYCLES(2), .FIFO_DEPTH(4)) dutA (
        .clk(clk), .rst_n(rst_n), .flush_i(flushA), .in_if(busA.slave),
        .sevenseg_out_o(segA), .busy_o(busyA), .fifo_level_o(lvlA)
    );

    hex_digit_sequencer #(.DWELL_CYCLES(4), .GAP_CYCLES(0), .FIFO_DEPTH(4)) dutB (
        .clk(clk), .rst_n(rst_n), .flush_i(flushB), .in_if(busB.slave),
        .sevenseg_out_o(segB), .busy_o(busyB), .fifo_level_o(lvlB)
    );

    logic [6:0] segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int         accQ[$];
    int         startQ[$];
    logic [7:0] wordQ[$];
    int         lastStart;
    int         cyc;
    int         gapM;
    int         total;
    int         bad;
    bit         sel;
    bit         took;

    function automatic logic [7:0] modelSeg();
        for (int i = 0; i < startQ.size(); i++)
            if (cyc >= startQ[i] && cyc < startQ[i] + D) return wordQ[i];
        return 8'hFF;
    endfunction

    function automatic int modelLevel();
        int n = 0;
        for (int i = 0; i < accQ.size(); i++)
            if (accQ[i] <= cyc && startQ[i] > cyc) n++;
        return n;
    endfunction

    function automatic bit modelBusy();
        for (int i = 0; i < accQ.size(); i++)
            if (accQ[i] <= cyc && cyc < startQ[i] + D + gapM) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] obsSeg();   return sel ? segB : segA;                     endfunction
    function automatic logic       obsBusy();  return sel ? busyB : busyA;                   endfunction
    function automatic logic [2:0] obsLvl();   return sel ? lvlB : lvlA;                     endfunction
    function automatic logic       obsReady(); return sel ? busB.in_ready : busA.in_ready;   endfunction

    task automatic modelClear();
        accQ.delete();
        startQ.delete();
        wordQ.delete();
        lastStart = -1000;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic dp, input logic fl);
        if (!sel) begin
            busA.in_valid = v; busA.in_data = d; busA.in_dp = dp; flushA = fl;
        end else begin
            busB.in_valid = v; busB.in_data = d; busB.in_dp = dp; flushB = fl;
        end
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic dp, input logic fl,
                        output bit accepted);
        bit rdy;
        int st;
        @(negedge clk);
        check("seg", obsSeg(), modelSeg());
        check("busy", {7'b0, obsBusy()}, {7'b0, modelBusy()});
        check("level", {5'b0, obsLvl()}, 8'(modelLevel()));
        rdy = !fl && (modelLevel() < DEPTH);
        drive(v, d, dp, fl);
        #1;
        check("ready", {7'b0, obsReady()}, {7'b0, rdy});
        @(posedge clk);
        cyc++;
        accepted = 1'b0;
        if (fl) begin
            modelClear();
        end else if (v && rdy) begin
            accepted = 1'b1;
            st = (cyc + 1 > lastStart + D + gapM) ? cyc + 1 : lastStart + D + gapM;
            accQ.push_back(cyc);
            startQ.push_back(st);
            wordQ.push_back(~{dp, segTab[d]});
            lastStart = st;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, a);
    endtask

    task automatic drain();
        bit a;
        for (int g = 0; g < 200 && modelBusy(); g++) step(1'b0, 4'h0, 1'b0, 1'b0, a);
        idle(2);
    endtask

    // Reset lands mid-cycle, so the blank must appear before any clock edge.
    task automatic asyncReset();
        @(negedge clk);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rstSeg", obsSeg(), 8'hFF);
        check("rstBusy", {7'b0, obsBusy()}, 8'h00);
        check("rstLevel", {5'b0, obsLvl()}, 8'h00);
        check("rstReady", {7'b0, obsReady()}, 8'h01);
        #1 rst_n = 1'b1;
        modelClear();
        @(posedge clk);
        cyc++;
    endtask

    task automatic randomRun(input int n);
        logic v, fl;
        for (int i = 0; i < n; i++) begin
            v  = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 39) == 0);
            step(v, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), fl, took);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        sel   = 1'b0;
        gapM  = 2;
        modelClear();
        busA.in_valid = 1'b0; busA.in_data = 4'h0; busA.in_dp = 1'b0;
        busB.in_valid = 1'b0; busB.in_data = 4'h0; busB.in_dp = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        check("resetSeg", segA, 8'hFF);
        check("resetReady", {7'b0, busA.in_ready}, 8'h01);
        check("resetBusy", {7'b0, busyA}, 8'h00);
        check("resetLevel", {5'b0, lvlA}, 8'h00);
        #9 rst_n = 1'b1;

        idle(5);

        step(1'b1, 4'h0, 1'b0, 1'b0, took);
        idle(9);

        step(1'b1, 4'hA, 1'b1, 1'b0, took);
        step(1'b1, 4'hF, 1'b0, 1'b0, took);
        idle(14);

        for (int dgt = 1; dgt <= 6; dgt++) begin
            took = 1'b0;
            for (int g = 0; g < 40 && !took; g++) step(1'b1, 4'(dgt), 1'b0, 1'b0, took);
        end
        drain();

        step(1'b1, 4'h3, 1'b0, 1'b0, took);
        idle(2);
        step(1'b1, 4'h5, 1'b0, 1'b1, took);
        idle(4);

        step(1'b1, 4'h3, 1'b0, 1'b0, took);
        idle(2);
        asyncReset();
        idle(3);

        randomRun(250);
        drain();

        drive(1'b0, 4'h0, 1'b0, 1'b0);
        sel  = 1'b1;
        gapM = 0;
        asyncReset();
        idle(2);
        step(1'b1, 4'h8, 1'b0, 1'b0, took);
        step(1'b1, 4'h8, 1'b0, 1'b0, took);
        idle(12);

        randomRun(150);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_digit_sequencer.md
Name: hex_digit_sequencer

Overview:
- Upstream stage of the seven-segment-to-LED-matrix converter. It produces the 8-bit active-low segment word that the converter consumes.
- Accepts hex digits, each with a decimal-point flag, over a valid/ready handshake into a small FIFO.
- Shows each digit for a fixed dwell time, then a blank gap, so that repeated digits stay distinguishable.
- Output is registered and glitch-free, ready to drive the matrix converter's segment input directly.

Parameters:
- DWELL_CYCLES, 32768: cycles each digit is displayed (>=1).
- GAP_CYCLES, 4096: blank cycles after each digit (0 = no gap).
- FIFO_DEPTH, 4: digit FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO and display
- in_valid  in  1  digit offered
- in_ready  out  1  digit can be accepted
- in_data  in  4  hex digit 0x0-0xF
- in_dp  in  1  light decimal point with this digit
- sevenseg_out  out  8  active-low segments; bit0=a .. bit6=g, bit7=dp; 0 = lit
- busy  out  1  FIFO non-empty or state != IDLE
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (async, immediate): FIFO empty; state IDLE; sevenseg_out=8'hFF; counter=0; fifo_level=0; in_ready=1; busy=0.
- Accept rule: push when in_valid & in_ready at a rising edge.
  - in_ready = !full & !flush. It does not depend on a same-cycle pop.
  - A slot freed by a pop raises in_ready on the next cycle.
- Encode: segment pattern (gfedcba, active-high) per digit 0-F:
  - 0-7: 3F 06 5B 4F 66 6D 7D 07
  - 8-F: 7F 6F 77 7C 39 5E 79 71
  - sevenseg_out = ~{dp, pattern}.
- FSM, counter width $clog2(max(DWELL,GAP)) :
  - IDLE: output FF. If FIFO non-empty: pop, load the encoded word, cnt=DWELL-1, go to SHOW.
  - SHOW: if cnt!=0, decrement. Else:
    - if GAP>0: output FF, cnt=GAP-1, go to GAP;
    - else if FIFO non-empty: pop, load the next word, cnt=DWELL-1, stay in SHOW;
    - else: output FF, go to IDLE.
  - GAP: output FF. If cnt!=0, decrement. Else:
    - if FIFO non-empty: pop, load, cnt=DWELL-1, go to SHOW;
    - else go to IDLE.
- Timing guarantees: each digit visible exactly DWELL_CYCLES cycles; each gap exactly GAP_CYCLES cycles.
- Latency: a digit pushed into an empty FIFO while IDLE appears on sevenseg_out one edge after the accepting edge.
- Simultaneous push and pop: both take effect; fifo_level is unchanged.
- Full FIFO: in_ready=0 and the producer holds its data. No overwrite, no drop.
- Empty FIFO: no pop is issued; the FSM idles with a blank display.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is exact, 0..FIFO_DEPTH.
- flush (priority over everything except reset):
  - at the next edge: FIFO emptied, state IDLE, sevenseg_out=FF, counter=0;
  - a push offered in the flush cycle is not accepted (in_ready=0).
- Reset mid-operation: output blanks asynchronously. Queued digits are lost.

Test Plan (DWELL_CYCLES=4, GAP_CYCLES=2, FIFO_DEPTH=4 unless stated):
- Reset release, no input -> sevenseg_out=FF, in_ready=1, busy=0, fifo_level=0 indefinitely.
- Push 0x0 (dp=0) at edge k:
  - sevenseg_out=C0 after edges k+1..k+4;
  - FF for the next 2 cycles, then FF in IDLE;
  - busy falls after the gap.
- Push 0xA with dp=1, then 0xF with dp=0 -> 08 for 4 cycles, FF for 2, 8E for 4, FF.
- Push six digits 1..6 on consecutive edges:
  - level reaches 4 after the 5th push; in_ready=0; digit 6 is held;
  - output sequence F9,A4,B0,99,92,82, each 4 cycles, separated by 2 FF cycles, none lost.
- GAP_CYCLES=0, push 8,8 -> sevenseg_out=80 for 8 contiguous cycles, then FF.
- Checks while digit 3 is showing:
  - assert flush for one cycle with in_valid=1 -> FF next edge, level=0, in_ready=0 during flush, the offered digit not accepted;
  - repeat with rst_n pulsed low -> FF immediately, before any clock edge.
